key_encoder: RTL and testbench

Source of the note-event stream consumed by the polyphonic player. It synchronises and debounces a bank of active-high key inputs and turns each debounced press or release into one 8-bit message: msg[7] = 1 for note-on, 0 for note-off, msg[6:0] = MIDI note. Messages are buffered in a small FIFO and presented on `msg` with a rising-edge strobe on `clk_msg`. Strobe timing is paced so a receiver in the same clock domain finishes each message before the next edge.

---
 rtl/piano_pkg.sv | 18 +
 rtl/msg_fifo.sv | 53 +++++
 rtl/key_encoder.sv | 146 ++++++++++++++
 tb/tb_key_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Definitions shared between the key encoder and the polyphonic player.
package piano_pkg;

    localparam int unsigned MSG_ON_BIT = 7;
    localparam logic [6:0]  NOTE_NONE  = 7'd0;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_SETUP = 2'd1;
    localparam tx_state_t TX_HIGH  = 2'd2;
    localparam tx_state_t TX_LOW   = 2'd3;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
    } note_msg_t;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO for note messages; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module msg_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/key_encoder.sv
// Debounces a key bank, scans it round-robin for net state changes and sends
// each change as an 8-bit note message framed by a paced strobe.
module key_encoder
    import piano_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 120_000_000,
    parameter int unsigned KEY_NUM         = 16,
    parameter int unsigned BASE_NOTE       = 60,
    parameter int unsigned DEBOUNCE_CYCLES = 1_200_000,
    parameter int unsigned STROBE_CYCLES   = 8,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] keys,
    output logic [7:0]         msg,
    output logic               clk_msg,
    output logic               busy,
    output logic               fifo_full
);

    localparam int unsigned SW  = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
    localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SCW = $clog2(STROBE_CYCLES + 1);

    if (CLK_FREQ == 0 || DEBOUNCE_CYCLES == 0 || STROBE_CYCLES == 0 ||
        BASE_NOTE < 1 || BASE_NOTE + KEY_NUM - 1 > 127) begin : g_param_check
        $error("key_encoder: illegal parameter set");
    end

    logic [KEY_NUM-1:0] sync1_q, sync2_q;
    logic [KEY_NUM-1:0] samp_q, samp_d, db_q, db_d, rep_q, rep_d, agree;
    logic [CW-1:0]      tick_cnt_q;
    logic               tick;

    assign tick = (tick_cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    // A key's debounced level only moves when two consecutive tick samples agree.
    always_comb begin
        agree  = ~(sync2_q ^ samp_q);
        samp_d = samp_q;
        db_d   = db_q;
        if (tick) begin
            samp_d = sync2_q;
            db_d   = (agree & sync2_q) | (~agree & db_q);
        end
    end

    logic [SW-1:0] scan_q, scan_d;
    logic          scan_push, fifo_empty, fifo_pop;
    note_msg_t     push_msg;
    logic [7:0]    fifo_rdata;

    assign push_msg.on   = db_q[scan_q];
    assign push_msg.note = 7'(BASE_NOTE) + 7'(scan_q);
    assign scan_push     = (db_q[scan_q] != rep_q[scan_q]) && !fifo_full;

    always_comb begin
        rep_d  = rep_q;
        scan_d = scan_q;
        if (scan_push) rep_d[scan_q] = db_q[scan_q];
        if (!fifo_full) scan_d = (scan_q == SW'(KEY_NUM - 1)) ? '0 : scan_q + 1'b1;
    end

    msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (scan_push),
        .wdata_i (push_msg),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    tx_state_t      state_q, state_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [7:0]     msg_q, msg_d;
    logic           clk_msg_q, clk_msg_d;

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        msg_d    = msg_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    msg_d    = fifo_rdata;
                    state_d  = TX_SETUP;
                end
            end
            TX_SETUP: begin
                scnt_d  = '0;
                state_d = TX_HIGH;
            end
            TX_HIGH, TX_LOW: begin
                if (scnt_q == SCW'(STROBE_CYCLES - 1)) begin
                    scnt_d  = '0;
                    state_d = (state_q == TX_HIGH) ? TX_LOW : TX_IDLE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        clk_msg_d = (state_d == TX_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            samp_q     <= '0;
            db_q       <= '0;
            rep_q      <= '0;
            tick_cnt_q <= '0;
            scan_q     <= '0;
            state_q    <= TX_IDLE;
            scnt_q     <= '0;
            msg_q      <= {1'b0, NOTE_NONE};
            clk_msg_q  <= 1'b0;
        end else begin
            sync1_q    <= keys;
            sync2_q    <= sync1_q;
            samp_q     <= samp_d;
            db_q       <= db_d;
            rep_q      <= rep_d;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            scan_q     <= scan_d;
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            msg_q      <= msg_d;
            clk_msg_q  <= clk_msg_d;
        end
    end

    assign msg     = msg_q;
    assign clk_msg = clk_msg_q;
    assign busy    = !fifo_empty || (state_q != TX_IDLE);

endmodule

// File: tb/tb_key_encoder.sv
// Directed bench for key_encoder: expected messages are queued as keys change
// and matched against each clk_msg rising edge.
`timescale 1ns/1ps
module tb_key_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0, keys_f = '0;
    logic [7:0]  msg, msg_f;
    logic        clk_msg, busy, fifo_full;
    logic        clk_msg_f, busy_f, fifo_full_f;

    key_encoder #(
        .CLK_FREQ(120_000_000), .KEY_NUM(16), .BASE_NOTE(60),
        .DEBOUNCE_CYCLES(100), .STROBE_CYCLES(8), .FIFO_DEPTH(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .msg(msg),
        .clk_msg(clk_msg), .busy(busy), .fifo_full(fifo_full)
    );

    // Second instance with a one-cycle debounce so the scanner can be held
    // stalled across a complete press/release of another key.
    key_encoder #(
        .CLK_FREQ(120_000_000), .KEY_NUM(16), .BASE_NOTE(60),
        .DEBOUNCE_CYCLES(1), .STROBE_CYCLES(8), .FIFO_DEPTH(8)
    ) u_fast (
        .clk(clk), .rst_n(rst_n), .keys(keys_f), .msg(msg_f),
        .clk_msg(clk_msg_f), .busy(busy_f), .fifo_full(fifo_full_f)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0, bad = 0;
    logic [7:0]  exp_q[$], exp_f[$];
    bit          unordered = 1'b0;
    int unsigned n_rise = 0, nf_rise = 0;
    int unsigned rise_t[$];

    function automatic int find_idx(input logic [7:0] q[$], input logic [7:0] v, input bit any_pos);
        if (q.size() == 0) return -1;
        if (!any_pos) return (q[0] === v) ? 0 : -1;
        for (int i = 0; i < q.size(); i++) if (q[i] === v) return i;
        return -1;
    endfunction

    logic        prev_cm = 1'b0;
    logic [7:0]  prev_msg = '0;
    int unsigned hi_len = 0;
    int          idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cm = 1'b0;
            hi_len  = 0;
        end else begin
            if (clk_msg && !prev_cm) begin
                total++;
                assert (msg === prev_msg) else begin
                    bad++; $error("FAIL setup_stable got=%h exp=%h", msg, prev_msg);
                end
                if (rise_t.size() > 0) begin
                    total++;
                    assert (cyc - rise_t[rise_t.size()-1] >= 18) else begin
                        bad++; $error("FAIL msg_period got=%0d exp>=18", cyc - rise_t[rise_t.size()-1]);
                    end
                end
                total++;
                idx = find_idx(exp_q, msg, unordered);
                assert (idx >= 0) else begin
                    bad++; $error("FAIL msg got=%h exp_head=%h pending=%0d", msg,
                                  (exp_q.size() > 0) ? exp_q[0] : 8'h00, exp_q.size());
                end
                if (idx >= 0) exp_q.delete(idx);
                n_rise++;
                rise_t.push_back(cyc);
                hi_len = 1;
            end else if (clk_msg) begin
                hi_len++;
            end else if (prev_cm) begin
                total++;
                assert (hi_len == 8) else begin
                    bad++; $error("FAIL strobe_high got=%0d exp=8", hi_len);
                end
            end
        end
        prev_cm  = clk_msg;
        prev_msg = msg;
    end

    logic prev_cmf = 1'b0;
    int   idx_f;
    always @(negedge clk) begin
        if (rst_n && clk_msg_f && !prev_cmf) begin
            total++;
            idx_f = find_idx(exp_f, msg_f, 1'b1);
            assert (idx_f >= 0) else begin
                bad++; $error("FAIL fast_msg got=%h pending=%0d", msg_f, exp_f.size());
            end
            if (idx_f >= 0) exp_f.delete(idx_f);
            nf_rise++;
        end
        prev_cmf = rst_n && clk_msg_f;
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
            step(1);
            n++;
        end
        total++;
        assert (exp_q.size() == 0 && busy === 1'b0) else begin
            bad++; $error("FAIL %s_drain got=pending %0d busy %b exp=pending 0 busy 0", tag, exp_q.size(), busy);
        end
        step(400);
    endtask

    initial begin
        int unsigned r0, n;
        logic [7:0]  m;

        step(3);
        check("rst_msg", msg, 8'h00);
        check("rst_clk_msg", clk_msg, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_full", fifo_full, 1'b0);
        rst_n = 1'b1;

        keys[3] = 1'b1; exp_q.push_back(8'hBF);
        drain("press3", 800);
        keys[3] = 1'b0; exp_q.push_back(8'h3F);
        drain("release3", 800);

        r0 = n_rise;
        keys[5] = 1'b1; step(50); keys[5] = 1'b0;
        step(400);
        check("glitch5_msgs", n_rise, r0);
        check("glitch5_busy", busy, 1'b0);

        keys[2:0] = 3'b111;
        exp_q.push_back(8'hBC); exp_q.push_back(8'hBD); exp_q.push_back(8'hBE);
        drain("keys012", 1000);
        n = rise_t.size();
        check("spacing_01", rise_t[n-2] - rise_t[n-3], 18);
        check("spacing_12", rise_t[n-1] - rise_t[n-2], 18);

        unordered = 1'b1;
        keys[15:4] = '1;
        for (int k = 4; k < 16; k++) begin
            m = 8'h80 | 8'(60 + k);
            exp_q.push_back(m);
        end
        n = 0;
        while (fifo_full !== 1'b1 && n < 600) begin step(1); n++; end
        check("fifo_full_set", fifo_full, 1'b1);
        drain("twelve_on", 2000);
        check("fifo_full_clear", fifo_full, 1'b0);

        keys = 16'h0080;
        for (int k = 0; k < 16; k++) begin
            m = 8'(60 + k);
            if (k != 3 && k != 7) exp_q.push_back(m);
        end
        drain("release_all", 2500);

        unordered = 1'b0;
        keys[3] = 1'b1; exp_q.push_back(8'hBF);
        r0 = n_rise; n = 0;
        while (n_rise == r0 && n < 800) begin step(1); n++; end
        check("rise_before_reset", n_rise, r0 + 1);
        step(3);
        rst_n = 1'b0; keys[3] = 1'b0;
        #1;
        check("reset_clk_msg", clk_msg, 1'b0);
        check("reset_msg", msg, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_fifo_full", fifo_full, 1'b0);
        exp_q.delete();
        step(5);
        rst_n = 1'b1;
        r0 = n_rise;
        exp_q.push_back(8'hC3);
        drain("held7", 800);
        check("held7_count", n_rise, r0 + 1);

        r0 = n_rise;
        exp_q.push_back(8'hC5);
        keys[9] = 1'b1; step(20); keys[9] = 1'b0; step(20);
        keys[9] = 1'b1; step(20); keys[9] = 1'b0; step(20);
        keys[9] = 1'b1;
        drain("bounce9", 1000);
        check("bounce9_count", n_rise, r0 + 1);

        keys_f = 16'h3FFF;
        for (int k = 0; k < 14; k++) begin
            m = 8'h80 | 8'(60 + k);
            exp_f.push_back(m);
        end
        n = 0;
        while (nf_rise < 2 && n < 300) begin step(1); n++; end
        check("fast_rises", nf_rise, 2);
        check("fast_stalled", fifo_full_f, 1'b1);
        keys_f[15] = 1'b1; step(3); keys_f[15] = 1'b0;
        n = 0;
        while ((exp_f.size() != 0 || busy_f !== 1'b0) && n < 1000) begin step(1); n++; end
        step(100);
        check("fast_pending", exp_f.size(), 0);
        check("fast_count", nf_rise, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
